// File: rtl/msrv32_load_wait_unit.sv
// Load unit for the msrv32 stage-3 writeback path: extracts/extends load data and
// freezes the pipeline while waiting on a slow data memory, with a bounded timeout.
module msrv32_load_wait_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  WB_LU_SEL      = 3'd1
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [2:0]  wb_mux_sel_in,
    input  logic        rf_wr_en_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] iadder_out_in,
    input  logic [31:0] dm_data_in,
    input  logic        dm_ready_in,
    output logic [31:0] lu_output_out,
    output logic        lu_valid_out,
    output logic        stall_out,
    output logic        misaligned_load_out,
    output logic        timeout_err_out
);

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic [1:0]  size_q, addr_q;
    logic        unsigned_q;

    logic        load_req, misaligned;
    logic [1:0]  ext_size, ext_addr;
    logic        ext_unsigned;
    logic [31:0] load_data;
    logic        take_data, take_mis, take_to, latch_en;
    logic        unused_addr_hi;

    function automatic logic [31:0] extract_load(input logic [31:0] data,
                                                 input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  addr);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr)
            2'b00:   b = data[7:0];
            2'b01:   b = data[15:8];
            2'b10:   b = data[23:16];
            default: b = data[31:24];
        endcase
        h = addr[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

    assign unused_addr_hi = ^iadder_out_in[31:2];
    assign load_req       = (wb_mux_sel_in == WB_LU_SEL) && rf_wr_en_in;
    assign misaligned     = is_misaligned(load_size_in, iadder_out_in[1:0]);

    // While waiting, the upstream stage may already hold a different instruction,
    // so extraction must use the fields captured when the load first arrived.
    assign ext_size     = (state == WAIT) ? size_q     : load_size_in;
    assign ext_addr     = (state == WAIT) ? addr_q     : iadder_out_in[1:0];
    assign ext_unsigned = (state == WAIT) ? unsigned_q : load_unsigned_in;
    assign load_data    = extract_load(dm_data_in, ext_size, ext_unsigned, ext_addr);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        stall_out    = 1'b0;
        take_data    = 1'b0;
        take_mis     = 1'b0;
        take_to      = 1'b0;
        latch_en     = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) begin
                    if (misaligned) begin
                        take_mis = 1'b1;
                    end else if (dm_ready_in) begin
                        take_data = 1'b1;
                    end else begin
                        stall_out    = 1'b1;
                        latch_en     = 1'b1;
                        wait_cnt_nxt = 8'd1;
                        state_nxt    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dm_ready_in) begin
                    take_data    = 1'b1;
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = IDLE;
                end else if (wait_cnt >= CNT_MAX) begin
                    take_to      = 1'b1;
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = IDLE;
                end else begin
                    stall_out    = 1'b1;
                    wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset_in) begin
            stall_out = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state               <= IDLE;
            wait_cnt            <= 8'd0;
            size_q              <= 2'b00;
            addr_q              <= 2'b00;
            unsigned_q          <= 1'b0;
            lu_output_out       <= 32'd0;
            lu_valid_out        <= 1'b0;
            misaligned_load_out <= 1'b0;
            timeout_err_out     <= 1'b0;
        end else begin
            state               <= state_nxt;
            wait_cnt            <= wait_cnt_nxt;
            lu_valid_out        <= take_data;
            misaligned_load_out <= take_mis;
            timeout_err_out     <= take_to;
            if (latch_en) begin
                size_q     <= load_size_in;
                addr_q     <= iadder_out_in[1:0];
                unsigned_q <= load_unsigned_in;
            end
            if (take_data) begin
                lu_output_out <= load_data;
            end else if (take_to) begin
                lu_output_out <= 32'd0;
            end
        end
    end

endmodule
